biriq_cmp_unit: RTL and testbench

- Parametrised, pipelined successor to the integer compare/select ALU slice.
- Generalises the operand width to XLEN.
- Adds conditional-branch evaluation with misprediction detection.
- Adds a 2-stage elastic valid/ready pipeline with flush. It sits in the IXU between issue and writeback/branch-resolve.

---
 rtl/biriq_cmp_unit.sv | 162 ++++++++++++++++
 tb/tb_biriq_cmp_unit.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/biriq_cmp_unit.sv
// Pipelined integer compare/select slice with branch resolution and a 2-stage elastic valid/ready pipeline.
// Optional branch statistics counters are enabled by defining BIRIQ_CMP_STATS_EN.
module biriq_cmp_unit #(
  parameter int unsigned XLEN                  = 32,
  parameter int unsigned TAG_W                 = 6,
  parameter int unsigned C_HAS_ZBB_EXTENSION   = 1,
  parameter int unsigned C_HAS_CZERO_EXTENSION = 1
) (
  input  logic             cpu_clock_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [XLEN-1:0]  a_i,
  input  logic [XLEN-1:0]  b_i,
  input  logic [3:0]       op_i,
  input  logic             pred_taken_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [XLEN-1:0]  c_o,
  output logic             taken_o,
  output logic             mispredict_o,
  output logic             is_branch_o,
  output logic [TAG_W-1:0] tag_o
`ifdef BIRIQ_CMP_STATS_EN
  ,
  output logic [31:0]      branch_cnt_o,
  output logic [31:0]      mispredict_cnt_o
`endif
);

  logic             s1_valid_q, s1_valid_d;
  logic [XLEN-1:0]  s1_a_q, s1_b_q;
  logic [3:0]       s1_op_q;
  logic             s1_pred_q;
  logic [TAG_W-1:0] s1_tag_q;

  logic             s2_valid_q, s2_valid_d;
  logic [XLEN-1:0]  s2_c_q, s2_c_d;
  logic             s2_taken_q, s2_taken_d;
  logic             s2_mis_q, s2_mis_d;
  logic             s2_br_q;
  logic [TAG_W-1:0] s2_tag_q;

  logic s1_load, s2_load, accept;
  logic eq, ltu, lts, bz;
  logic [XLEN-1:0] alu_c;

  // A stage loads when empty or when its occupant leaves on the same edge.
  always_comb begin
    s2_load    = !s2_valid_q || ready_i;
    s1_load    = !s1_valid_q || s2_load;
    ready_o    = s1_load;
    accept     = valid_i && s1_load && !flush_i;
    s1_valid_d = s1_load ? accept : s1_valid_q;
    s2_valid_d = s2_load ? s1_valid_q : s2_valid_q;
    if (flush_i) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end
  end

  // Signed less-than derived from the unsigned compare plus the sign bits.
  always_comb begin
    eq  = (s1_a_q == s1_b_q);
    ltu = (s1_a_q < s1_b_q);
    lts = (s1_a_q[XLEN-1] != s1_b_q[XLEN-1]) ? s1_a_q[XLEN-1] : ltu;
    bz  = (s1_b_q == '0);
  end

  always_comb begin
    alu_c      = '0;
    s2_taken_d = 1'b0;
    if (s1_op_q[3]) begin
      case (s1_op_q[2:0])
        3'b000:  s2_taken_d = eq;
        3'b001:  s2_taken_d = !eq;
        3'b100:  s2_taken_d = lts;
        3'b101:  s2_taken_d = !lts;
        3'b110:  s2_taken_d = ltu;
        3'b111:  s2_taken_d = !ltu;
        default: s2_taken_d = 1'b0;
      endcase
    end else begin
      case (s1_op_q[2:0])
        3'b000:  alu_c = (C_HAS_ZBB_EXTENSION != 0) ? (ltu ? s1_b_q : s1_a_q) : '0;
        3'b001:  alu_c = (C_HAS_ZBB_EXTENSION != 0) ? ((ltu || eq) ? s1_a_q : s1_b_q) : '0;
        3'b010:  alu_c = XLEN'(lts);
        3'b011:  alu_c = XLEN'(ltu);
        3'b100:  alu_c = (C_HAS_ZBB_EXTENSION != 0) ? (lts ? s1_b_q : s1_a_q) : '0;
        3'b101:  alu_c = (C_HAS_ZBB_EXTENSION != 0) ? ((lts || eq) ? s1_a_q : s1_b_q) : '0;
        3'b110:  alu_c = (C_HAS_CZERO_EXTENSION != 0) ? (bz ? '0 : s1_a_q) : '0;
        default: alu_c = (C_HAS_CZERO_EXTENSION != 0) ? (bz ? s1_a_q : '0) : '0;
      endcase
    end
    s2_c_d   = s1_op_q[3] ? XLEN'(s2_taken_d) : alu_c;
    s2_mis_d = s1_op_q[3] && (s2_taken_d ^ s1_pred_q);
  end

  always_ff @(posedge cpu_clock_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_op_q    <= '0;
      s1_pred_q  <= 1'b0;
      s1_tag_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_c_q     <= '0;
      s2_taken_q <= 1'b0;
      s2_mis_q   <= 1'b0;
      s2_br_q    <= 1'b0;
      s2_tag_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      if (accept) begin
        s1_a_q    <= a_i;
        s1_b_q    <= b_i;
        s1_op_q   <= op_i;
        s1_pred_q <= pred_taken_i;
        s1_tag_q  <= tag_i;
      end
      if (s2_load && s1_valid_q) begin
        s2_c_q     <= s2_c_d;
        s2_taken_q <= s2_taken_d;
        s2_mis_q   <= s2_mis_d;
        s2_br_q    <= s1_op_q[3];
        s2_tag_q   <= s1_tag_q;
      end
    end
  end

  assign valid_o      = s2_valid_q;
  assign c_o          = s2_c_q;
  assign taken_o      = s2_taken_q;
  assign mispredict_o = s2_mis_q;
  assign is_branch_o  = s2_br_q;
  assign tag_o        = s2_tag_q;

`ifdef BIRIQ_CMP_STATS_EN
  logic [31:0] br_cnt_q, mis_cnt_q;
  logic        consume_br;

  assign consume_br = s2_valid_q && ready_i && s2_br_q;

  always_ff @(posedge cpu_clock_i or negedge rst_ni) begin
    if (!rst_ni) begin
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else begin
      if (consume_br && (br_cnt_q != '1)) br_cnt_q <= br_cnt_q + 32'd1;
      if (consume_br && s2_mis_q && (mis_cnt_q != '1)) mis_cnt_q <= mis_cnt_q + 32'd1;
    end
  end

  assign branch_cnt_o     = br_cnt_q;
  assign mispredict_cnt_o = mis_cnt_q;
`endif

endmodule

// File: tb/tb_biriq_cmp_unit.sv
// Directed self-checking bench for biriq_cmp_unit: 32-bit instance for ALU/branch/pipeline behaviour,
// 64-bit instance for width-dependent compares.
module tb_biriq_cmp_unit;

  logic        clk;
  logic        rst_n;
  logic        flush_i, valid_i, ready_i, pred_i;
  logic [31:0] a_i, b_i;
  logic [3:0]  op_i;
  logic [5:0]  tag_i;
  logic        ready_o, valid_o, taken_o, mis_o, br_o;
  logic [31:0] c_o;
  logic [5:0]  tag_o;

  logic        w_valid_i, w_pred_i, w_ready_o, w_valid_o, w_taken_o, w_mis_o, w_br_o;
  logic [63:0] w_a_i, w_b_i, w_c_o;
  logic [3:0]  w_op_i;
  logic [5:0]  w_tag_i, w_tag_o;

`ifdef BIRIQ_CMP_STATS_EN
  logic [31:0] br_cnt, mis_cnt, w_br_cnt, w_mis_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  biriq_cmp_unit #(.XLEN(32), .TAG_W(6)) dut (
    .cpu_clock_i(clk), .rst_ni(rst_n), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
    .a_i(a_i), .b_i(b_i), .op_i(op_i), .pred_taken_i(pred_i), .tag_i(tag_i),
    .valid_o(valid_o), .ready_i(ready_i), .c_o(c_o), .taken_o(taken_o),
    .mispredict_o(mis_o), .is_branch_o(br_o), .tag_o(tag_o)
`ifdef BIRIQ_CMP_STATS_EN
    , .branch_cnt_o(br_cnt), .mispredict_cnt_o(mis_cnt)
`endif
  );

  biriq_cmp_unit #(.XLEN(64), .TAG_W(6)) dut64 (
    .cpu_clock_i(clk), .rst_ni(rst_n), .flush_i(1'b0), .valid_i(w_valid_i), .ready_o(w_ready_o),
    .a_i(w_a_i), .b_i(w_b_i), .op_i(w_op_i), .pred_taken_i(w_pred_i), .tag_i(w_tag_i),
    .valid_o(w_valid_o), .ready_i(1'b1), .c_o(w_c_o), .taken_o(w_taken_o),
    .mispredict_o(w_mis_o), .is_branch_o(w_br_o), .tag_o(w_tag_o)
`ifdef BIRIQ_CMP_STATS_EN
    , .branch_cnt_o(w_br_cnt), .mispredict_cnt_o(w_mis_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic        pred;
    logic [31:0] c;
    logic        t;
    logic        m;
  } vec_t;

  // Presents one op for a single cycle, then returns two negedges later when its result is visible.
  task automatic send_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                         input logic pred, input logic [5:0] tag);
    ready_i = 1'b1; valid_i = 1'b1; a_i = a; b_i = b; op_i = op; pred_i = pred; tag_i = tag;
    @(negedge clk);
    valid_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic drain;
    valid_i = 1'b0; ready_i = 1'b1; flush_i = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({valid_o, c_o, taken_o, mis_o, br_o, tag_o} !== '0)
      begin n_err++; $display("FAIL reset_outputs: got %h expected 0", {valid_o, c_o, taken_o, mis_o, br_o, tag_o}); end
    n_vec++;
    if (ready_o !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b expected 1", ready_o); end
    n_vec++;
    if ({w_valid_o, w_c_o} !== '0) begin n_err++; $display("FAIL reset_outputs64: got %h expected 0", {w_valid_o, w_c_o}); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_alu_branch;
    vec_t v [20];
    logic [40:0] exp_v, got_v;
    v[0]  = '{32'hFFFF_FFFF, 32'd1, 4'b0000, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0};
    v[1]  = '{32'hFFFF_FFFF, 32'd1, 4'b0100, 1'b0, 32'd1,         1'b0, 1'b0};
    v[2]  = '{32'hFFFF_FFFF, 32'd1, 4'b0001, 1'b0, 32'd1,         1'b0, 1'b0};
    v[3]  = '{32'hFFFF_FFFF, 32'd1, 4'b0101, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0};
    v[4]  = '{32'hFFFF_FFFF, 32'd1, 4'b0010, 1'b0, 32'd1,         1'b0, 1'b0};
    v[5]  = '{32'hFFFF_FFFF, 32'd1, 4'b0011, 1'b0, 32'd0,         1'b0, 1'b0};
    v[6]  = '{32'd7,         32'd7, 4'b0010, 1'b0, 32'd0,         1'b0, 1'b0};
    v[7]  = '{32'd1234,      32'd0, 4'b0110, 1'b0, 32'd0,         1'b0, 1'b0};
    v[8]  = '{32'd1234,      32'd5, 4'b0110, 1'b0, 32'd1234,      1'b0, 1'b0};
    v[9]  = '{32'd1234,      32'd0, 4'b0111, 1'b0, 32'd1234,      1'b0, 1'b0};
    v[10] = '{32'd1234,      32'd5, 4'b0111, 1'b0, 32'd0,         1'b0, 1'b0};
    v[11] = '{32'h8000_0000, 32'd0, 4'b1100, 1'b0, 32'd1,         1'b1, 1'b1};
    v[12] = '{32'd5,         32'd5, 4'b1000, 1'b1, 32'd1,         1'b1, 1'b0};
    v[13] = '{32'd5,         32'd5, 4'b1001, 1'b1, 32'd0,         1'b0, 1'b1};
    v[14] = '{32'h8000_0000, 32'd0, 4'b1101, 1'b0, 32'd0,         1'b0, 1'b0};
    v[15] = '{32'h8000_0000, 32'd0, 4'b1110, 1'b0, 32'd0,         1'b0, 1'b0};
    v[16] = '{32'h8000_0000, 32'd0, 4'b1111, 1'b1, 32'd1,         1'b1, 1'b0};
    v[17] = '{32'd3,         32'd3, 4'b1010, 1'b1, 32'd0,         1'b0, 1'b1};
    v[18] = '{32'd3,         32'd3, 4'b1101, 1'b0, 32'd1,         1'b1, 1'b1};
    v[19] = '{32'h7FFF_FFFF, 32'h8000_0000, 4'b0100, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b0};
    for (int i = 0; i < 20; i++) begin
      send_op(v[i].a, v[i].b, v[i].op, v[i].pred, 6'(i + 1));
      exp_v = {1'b1, v[i].c, v[i].t, v[i].m, v[i].op[3], 6'(i + 1)};
      got_v = {valid_o, c_o, taken_o, mis_o, br_o, tag_o};
      n_vec++;
      if (got_v !== exp_v) begin
        n_err++;
        $display("FAIL vec%0d op=%b: got v/c/t/m/br/tag=%h expected %h", i, v[i].op, got_v, exp_v);
      end
    end
    drain();
  endtask

  task automatic test_back_to_back;
    logic [31:0] got_c [$];
    logic [5:0]  got_t [$];
    int idx;
    idx = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      ready_i = (cyc == 0) || (cyc >= 5);
      if (idx < 4) begin
        valid_i = 1'b1; a_i = 32'(11 * (idx + 1)); b_i = '0; op_i = 4'b0000; pred_i = 1'b0; tag_i = 6'(idx + 1);
      end else begin
        valid_i = 1'b0;
      end
      #1;
      if (cyc == 2) begin
        n_vec++;
        if (ready_o !== 1'b0) begin n_err++; $display("FAIL b2b_ready_drop: got %b expected 0", ready_o); end
      end
      if (cyc >= 2 && cyc <= 4) begin
        n_vec++;
        if ({valid_o, c_o, tag_o} !== {1'b1, 32'd11, 6'd1}) begin
          n_err++; $display("FAIL b2b_hold cyc%0d: got v=%b c=%h tag=%0d expected v=1 c=0000000b tag=1", cyc, valid_o, c_o, tag_o);
        end
      end
      if (valid_o && ready_i) begin got_c.push_back(c_o); got_t.push_back(tag_o); end
      if (valid_i && ready_o) idx++;
      @(negedge clk);
    end
    n_vec++;
    if (got_c.size() != 4) begin n_err++; $display("FAIL b2b_count: got %0d results expected 4", got_c.size()); end
    for (int i = 0; i < got_c.size() && i < 4; i++) begin
      n_vec++;
      if ({got_c[i], got_t[i]} !== {32'(11 * (i + 1)), 6'(i + 1)}) begin
        n_err++; $display("FAIL b2b_order%0d: got c=%0d tag=%0d expected c=%0d tag=%0d", i, got_c[i], got_t[i], 11 * (i + 1), i + 1);
      end
    end
    drain();
  endtask

  task automatic test_flush;
    bit seen;
    ready_i = 1'b0; valid_i = 1'b1; a_i = 32'd100; b_i = '0; op_i = 4'b0000; pred_i = 1'b0; tag_i = 6'd10;
    @(negedge clk);
    a_i = 32'd200; tag_i = 6'd11;
    @(negedge clk);
    valid_i = 1'b0;
    n_vec++;
    if ({valid_o, tag_o} !== {1'b1, 6'd10}) begin n_err++; $display("FAIL flush_pre: got v=%b tag=%0d expected v=1 tag=10", valid_o, tag_o); end
    flush_i = 1'b1; valid_i = 1'b1; tag_i = 6'd12;
    @(negedge clk);
    flush_i = 1'b0; valid_i = 1'b0;
    n_vec++;
    if (valid_o !== 1'b0) begin n_err++; $display("FAIL flush_clear: got valid_o=%b expected 0", valid_o); end
    ready_i = 1'b1;
    seen = 1'b0;
    repeat (6) begin @(negedge clk); seen |= valid_o; end
    valid_i = 1'b1; tag_i = 6'd13; flush_i = 1'b1;
    #1;
    n_vec++;
    if (ready_o !== 1'b1) begin n_err++; $display("FAIL flush_ready: got %b expected 1", ready_o); end
    @(negedge clk);
    valid_i = 1'b0; flush_i = 1'b0;
    repeat (4) begin @(negedge clk); seen |= valid_o; end
    n_vec++;
    if (seen !== 1'b0) begin n_err++; $display("FAIL flush_no_result: got valid_o seen=%b expected 0", seen); end
    drain();
  endtask

  task automatic test_xlen64;
    logic [63:0] wa [5];
    logic [63:0] wb [5];
    logic [3:0]  wop [5];
    logic        wp [5];
    logic [63:0] wc [5];
    logic        wt [5];
    logic        wm [5];
    wa[0] = 64'h1_0000_0000;         wb[0] = 64'hFFFF_FFFF; wop[0] = 4'b0011; wp[0] = 1'b0; wc[0] = '0;  wt[0] = 1'b0; wm[0] = 1'b0;
    wa[1] = 64'h1_0000_0000;         wb[1] = 64'hFFFF_FFFF; wop[1] = 4'b1110; wp[1] = 1'b1; wc[1] = '0;  wt[1] = 1'b0; wm[1] = 1'b1;
    wa[2] = 64'h8000_0000_0000_0000; wb[2] = 64'd1;         wop[2] = 4'b0010; wp[2] = 1'b0; wc[2] = 64'd1; wt[2] = 1'b0; wm[2] = 1'b0;
    wa[3] = 64'h0000_0000_8000_0000; wb[3] = 64'd1;         wop[3] = 4'b0010; wp[3] = 1'b0; wc[3] = '0;  wt[3] = 1'b0; wm[3] = 1'b0;
    wa[4] = 64'hFFFF_FFFF_FFFF_FFFF; wb[4] = 64'd1;         wop[4] = 4'b0000; wp[4] = 1'b0; wc[4] = 64'hFFFF_FFFF_FFFF_FFFF; wt[4] = 1'b0; wm[4] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      w_valid_i = 1'b1; w_a_i = wa[i]; w_b_i = wb[i]; w_op_i = wop[i]; w_pred_i = wp[i]; w_tag_i = 6'(40 + i);
      @(negedge clk);
      w_valid_i = 1'b0;
      @(negedge clk);
      n_vec++;
      if ({w_valid_o, w_c_o, w_taken_o, w_mis_o, w_tag_o} !== {1'b1, wc[i], wt[i], wm[i], 6'(40 + i)}) begin
        n_err++;
        $display("FAIL x64_vec%0d op=%b: got v=%b c=%h t=%b m=%b tag=%0d expected c=%h t=%b m=%b tag=%0d",
                 i, wop[i], w_valid_o, w_c_o, w_taken_o, w_mis_o, w_tag_o, wc[i], wt[i], wm[i], 40 + i);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_async_reset;
    bit seen;
    ready_i = 1'b0; valid_i = 1'b1; a_i = 32'd55; b_i = 32'd9; op_i = 4'b1001; pred_i = 1'b0; tag_i = 6'd20;
    @(negedge clk);
    tag_i = 6'd21;
    @(negedge clk);
    valid_i = 1'b0;
    n_vec++;
    if ({valid_o, tag_o} !== {1'b1, 6'd20}) begin n_err++; $display("FAIL rst_pre: got v=%b tag=%0d expected v=1 tag=20", valid_o, tag_o); end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({valid_o, c_o, taken_o, mis_o, br_o, tag_o} !== '0)
      begin n_err++; $display("FAIL rst_async: got %h expected 0", {valid_o, c_o, taken_o, mis_o, br_o, tag_o}); end
`ifdef BIRIQ_CMP_STATS_EN
    n_vec++;
    if ({br_cnt, mis_cnt} !== '0) begin n_err++; $display("FAIL rst_counters: got br=%0d mis=%0d expected 0 0", br_cnt, mis_cnt); end
`endif
    @(negedge clk);
    rst_n = 1'b1; ready_i = 1'b1;
    seen = 1'b0;
    repeat (5) begin @(negedge clk); seen |= valid_o; end
    n_vec++;
    if (seen !== 1'b0) begin n_err++; $display("FAIL rst_no_pulse: got valid_o seen=%b expected 0", seen); end
  endtask

`ifdef BIRIQ_CMP_STATS_EN
  task automatic test_stats;
    send_op(32'd1, 32'd1, 4'b1000, 1'b1, 6'd30);
    send_op(32'd1, 32'd1, 4'b1001, 1'b0, 6'd31);
    send_op(32'd0, 32'd1, 4'b1100, 1'b0, 6'd32);
    send_op(32'd4, 32'd1, 4'b0000, 1'b0, 6'd33);
    @(negedge clk);
    n_vec++;
    if ({br_cnt, mis_cnt} !== {32'd3, 32'd1}) begin
      n_err++; $display("FAIL stats_counts: got br=%0d mis=%0d expected 3 1", br_cnt, mis_cnt);
    end
  endtask
`endif

  initial begin
    rst_n = 1'b0; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1; pred_i = 1'b0;
    a_i = '0; b_i = '0; op_i = '0; tag_i = '0;
    w_valid_i = 1'b0; w_pred_i = 1'b0; w_a_i = '0; w_b_i = '0; w_op_i = '0; w_tag_i = '0;
    test_reset();
    test_alu_branch();
    test_back_to_back();
    test_flush();
    test_xlen64();
    test_async_reset();
`ifdef BIRIQ_CMP_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
